// File: rtl/sponge_ctrl.sv
// rtl/sponge_ctrl.sv - sequencing FSM for the multi-block Keccak sponge absorb/permute flow
module sponge_ctrl #(
   parameter int NUM_ROUNDS = 24,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             start,
   input  logic             blk_valid,
   input  logic             blk_last,
   input  logic             rounds_done,
   input  logic             digest_ack,
   output logic             blk_ready,
   output logic             state_clear,
   output logic             absorb_en,
   output logic             perm_en,
   output logic             busy,
   output logic             digest_valid,
   output logic             error,
   output logic [CNT_W-1:0] block_count
);

   // Watchdog counts PERMUTE cycles from 0; it fires in the cycle where it reads NUM_ROUNDS+3.
   localparam int              WD_W     = $clog2(NUM_ROUNDS + 4);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(NUM_ROUNDS + 3);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [2:0] {
      IDLE, CLEAR, WAIT_BLK, ABSORB, PERMUTE, DONE, ERROR
   } state_t;

   state_t          state_q, state_d;
   logic            last_q;
   logic [WD_W-1:0] wd_q;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state decode; nothing advances while enable is low
   always_comb begin
      state_d = state_q;
      if (enable) begin
         case (state_q)
            IDLE:     if (start) state_d = CLEAR;
            CLEAR:    state_d = WAIT_BLK;
            WAIT_BLK: if (blk_valid) state_d = ABSORB;
            ABSORB:   state_d = PERMUTE;
            PERMUTE: begin
               // Completion wins over a coincident watchdog expiry
               if (rounds_done)          state_d = last_q ? DONE : WAIT_BLK;
               else if (wd_q == WD_LIMIT) state_d = ERROR;
            end
            DONE:     if (digest_ack) state_d = IDLE;
            ERROR:    state_d = ERROR;
            default:  state_d = IDLE;
         endcase
      end
   end

   // Output decode: strobes gated by enable, status flags follow the state alone
   always_comb begin
      blk_ready    = enable && (state_q == WAIT_BLK);
      state_clear  = enable && (state_q == CLEAR);
      absorb_en    = enable && (state_q == ABSORB);
      perm_en      = enable && (state_q == PERMUTE);
      busy         = (state_q != IDLE);
      digest_valid = (state_q == DONE);
      error        = (state_q == ERROR);
   end

   // Block counter, last-block flag and permutation watchdog
   always_ff @(posedge clk) begin
      if (reset) begin
         block_count <= '0;
         last_q      <= 1'b0;
         wd_q        <= '0;
      end else if (enable) begin
         case (state_q)
            CLEAR: block_count <= '0;
            WAIT_BLK: begin
               if (blk_valid) begin
                  last_q <= blk_last;
                  if (block_count != CNT_MAX) block_count <= block_count + CNT_W'(1);
               end
            end
            ABSORB:  wd_q <= '0;
            PERMUTE: wd_q <= wd_q + WD_W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sponge_ctrl.sv
// tb/tb_sponge_ctrl.sv - scoreboard bench for sponge_ctrl with directed message sequences
module tb_sponge_ctrl;

   logic clk = 1'b0;
   logic reset, enable, start, blk_valid, blk_last, rounds_done, digest_ack;
   logic blk_ready, state_clear, absorb_en, perm_en, busy, digest_valid, error;
   logic [15:0] block_count;
   logic u2_blk_ready, u2_state_clear, u2_absorb_en, u2_perm_en, u2_busy, u2_digest_valid, u2_error;
   logic [1:0] u2_block_count;

   sponge_ctrl #(.NUM_ROUNDS(24), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .enable(enable), .start(start),
      .blk_valid(blk_valid), .blk_last(blk_last), .rounds_done(rounds_done),
      .digest_ack(digest_ack), .blk_ready(blk_ready), .state_clear(state_clear),
      .absorb_en(absorb_en), .perm_en(perm_en), .busy(busy),
      .digest_valid(digest_valid), .error(error), .block_count(block_count)
   );

   sponge_ctrl #(.NUM_ROUNDS(24), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .enable(enable), .start(start),
      .blk_valid(blk_valid), .blk_last(blk_last), .rounds_done(rounds_done),
      .digest_ack(digest_ack), .blk_ready(u2_blk_ready), .state_clear(u2_state_clear),
      .absorb_en(u2_absorb_en), .perm_en(u2_perm_en), .busy(u2_busy),
      .digest_valid(u2_digest_valid), .error(u2_error), .block_count(u2_block_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   localparam int K_CLR = 0;
   localparam int K_ABS = 1;
   localparam int K_DV  = 2;
   localparam int K_ERR = 3;

   typedef struct {
      int kind;
      int cyc;
      int cnt;
      int cnt2;
   } ev_t;

   ev_t exp_q[$];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_ev(input int kind, input int t, input int cnt, input int cnt2);
      ev_t e;
      e.kind = kind;
      e.cyc  = t;
      e.cnt  = cnt;
      e.cnt2 = cnt2;
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) step();
   endtask

   function automatic int outs();
      return int'({blk_ready, state_clear, absorb_en, perm_en, busy, digest_valid, error});
   endfunction

   // Monitor: turns DUT strobes into events and checks them against the scoreboard
   initial begin
      int   kind;
      ev_t  e;
      logic dv_d;
      logic err_d;
      dv_d  = 1'b0;
      err_d = 1'b0;
      forever begin
         @(negedge clk);
         kind = -1;
         if (state_clear)                  kind = K_CLR;
         else if (absorb_en)               kind = K_ABS;
         else if (digest_valid && !dv_d)   kind = K_DV;
         else if (error && !err_d)         kind = K_ERR;
         dv_d  = digest_valid;
         err_d = error;
         if (!enable)
            chk("strobe_while_disabled",
                int'({state_clear, absorb_en, perm_en, blk_ready}), 0);
         if (kind >= 0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_event_kind", kind, -1);
            end else begin
               e = exp_q.pop_front();
               chk("event_kind", kind, e.kind);
               chk("event_cycle", cyc, e.cyc);
               if (e.cnt >= 0) begin
                  chk("block_count", int'(block_count), e.cnt);
                  chk("block_count_w2", int'(u2_block_count), e.cnt2);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
      $fatal(1, "bench timeout");
   end

   int c;

   initial begin
      reset = 1'b1; enable = 1'b1; start = 1'b0; blk_valid = 1'b0;
      blk_last = 1'b0; rounds_done = 1'b0; digest_ack = 1'b0;
      step(); step();
      chk("outputs_in_reset", outs(), 0);
      reset = 1'b0;
      step();
      chk("outputs_after_reset", outs(), 0);
      chk("count_after_reset", int'(block_count), 0);

      // Spurious digest_ack / rounds_done in IDLE must not move the FSM
      digest_ack = 1'b1; rounds_done = 1'b1;
      step(); step();
      digest_ack = 1'b0; rounds_done = 1'b0;
      chk("idle_ignores_ack", outs(), 0);

      // Single block, rounds_done in the 24th PERMUTE cycle
      c = cyc;
      start = 1'b1; blk_valid = 1'b1; blk_last = 1'b1;
      expect_ev(K_CLR, c + 1, -1, -1);
      expect_ev(K_ABS, c + 3, 1, 1);
      expect_ev(K_DV,  c + 28, 1, 1);
      step(); start = 1'b0;
      wait_until(c + 3); blk_valid = 1'b0; blk_last = 1'b0;
      wait_until(c + 27); rounds_done = 1'b1; step(); rounds_done = 1'b0;
      wait_until(c + 30);
      chk("digest_held", int'(digest_valid), 1);
      digest_ack = 1'b1; step(); digest_ack = 1'b0;
      chk("busy_after_ack", int'(busy), 0);
      chk("sb_drained_single", exp_q.size(), 0);

      // Three blocks, 5-cycle blk_valid gap, spurious start/rounds_done
      c = cyc;
      start = 1'b1; blk_valid = 1'b1; blk_last = 1'b0;
      expect_ev(K_CLR, c + 1, -1, -1);
      expect_ev(K_ABS, c + 3, 1, 1);
      expect_ev(K_ABS, c + 17, 2, 2);
      expect_ev(K_ABS, c + 22, 3, 3);
      expect_ev(K_DV,  c + 26, 3, 3);
      step(); start = 1'b0;
      wait_until(c + 3); blk_valid = 1'b0;
      wait_until(c + 5); start = 1'b1; step(); start = 1'b0;
      wait_until(c + 10); rounds_done = 1'b1; step(); rounds_done = 1'b0;
      wait_until(c + 12); rounds_done = 1'b1; step(); rounds_done = 1'b0;
      chk("blk_ready_gap_a", int'(blk_ready), 1);
      wait_until(c + 15);
      chk("blk_ready_gap_b", int'(blk_ready), 1);
      wait_until(c + 16); blk_valid = 1'b1; step(); blk_valid = 1'b0;
      wait_until(c + 20); rounds_done = 1'b1; step(); rounds_done = 1'b0;
      blk_valid = 1'b1; blk_last = 1'b1; step(); blk_valid = 1'b0; blk_last = 1'b0;
      wait_until(c + 25); rounds_done = 1'b1; step(); rounds_done = 1'b0;
      wait_until(c + 27); digest_ack = 1'b1; step(); digest_ack = 1'b0;
      chk("busy_after_multi", int'(busy), 0);
      chk("sb_drained_multi", exp_q.size(), 0);

      // Enable low 2 cycles in WAIT_BLK and 4 cycles in PERMUTE; rounds_done at 28th enabled PERMUTE cycle
      c = cyc;
      start = 1'b1; blk_valid = 1'b1; blk_last = 1'b1;
      expect_ev(K_CLR, c + 1, -1, -1);
      expect_ev(K_ABS, c + 5, 1, 1);
      expect_ev(K_DV,  c + 38, 1, 1);
      step(); start = 1'b0;
      wait_until(c + 2); enable = 1'b0;
      wait_until(c + 4); enable = 1'b1;
      wait_until(c + 5); blk_valid = 1'b0; blk_last = 1'b0;
      wait_until(c + 10); enable = 1'b0;
      wait_until(c + 11); rounds_done = 1'b1; step(); rounds_done = 1'b0;
      wait_until(c + 14); enable = 1'b1;
      wait_until(c + 37); rounds_done = 1'b1; step(); rounds_done = 1'b0;
      chk("no_error_enable_run", int'(error), 0);
      wait_until(c + 39); digest_ack = 1'b1; step(); digest_ack = 1'b0;
      chk("sb_drained_enable", exp_q.size(), 0);

      // Watchdog expiry, sticky error, start ignored, reset clears
      c = cyc;
      start = 1'b1; blk_valid = 1'b1; blk_last = 1'b1;
      expect_ev(K_CLR, c + 1, -1, -1);
      expect_ev(K_ABS, c + 3, 1, 1);
      expect_ev(K_ERR, c + 32, 1, 1);
      step(); start = 1'b0;
      wait_until(c + 3); blk_valid = 1'b0; blk_last = 1'b0;
      wait_until(c + 31);
      chk("no_error_before_limit", int'(error), 0);
      wait_until(c + 33);
      chk("error_set", int'(error), 1);
      start = 1'b1; step(); step(); start = 1'b0;
      chk("error_sticky", int'(error), 1);
      chk("busy_in_error", int'(busy), 1);
      chk("sb_drained_wd", exp_q.size(), 0);
      reset = 1'b1; step(); reset = 1'b0;
      chk("outputs_after_error_reset", outs(), 0);

      // rounds_done exactly on the timeout cycle wins
      c = cyc;
      start = 1'b1; blk_valid = 1'b1; blk_last = 1'b1;
      expect_ev(K_CLR, c + 1, -1, -1);
      expect_ev(K_ABS, c + 3, 1, 1);
      expect_ev(K_DV,  c + 32, 1, 1);
      step(); start = 1'b0;
      wait_until(c + 3); blk_valid = 1'b0; blk_last = 1'b0;
      wait_until(c + 31); rounds_done = 1'b1; step(); rounds_done = 1'b0;
      chk("no_error_at_limit", int'(error), 0);
      digest_ack = 1'b1; step(); digest_ack = 1'b0;
      chk("sb_drained_limit", exp_q.size(), 0);

      // Reset during PERMUTE of the second block, then a fresh start
      c = cyc;
      start = 1'b1; blk_valid = 1'b1; blk_last = 1'b0;
      expect_ev(K_CLR, c + 1, -1, -1);
      expect_ev(K_ABS, c + 3, 1, 1);
      expect_ev(K_ABS, c + 10, 2, 2);
      step(); start = 1'b0;
      wait_until(c + 3); blk_valid = 1'b0;
      wait_until(c + 8); rounds_done = 1'b1; step(); rounds_done = 1'b0;
      blk_valid = 1'b1; step(); blk_valid = 1'b0;
      wait_until(c + 13); reset = 1'b1; step(); reset = 1'b0;
      chk("outputs_after_mid_reset", outs(), 0);
      chk("count_after_mid_reset", int'(block_count), 0);
      c = cyc;
      start = 1'b1;
      expect_ev(K_CLR, c + 1, -1, -1);
      step(); start = 1'b0; step();
      chk("count_after_fresh_clear", int'(block_count), 0);
      chk("ready_after_fresh_clear", int'(blk_ready), 1);
      reset = 1'b1; step(); reset = 1'b0;
      chk("sb_drained_reset", exp_q.size(), 0);

      // Five back-to-back blocks: 16-bit counter reaches 5, 2-bit counter saturates at 3
      c = cyc;
      start = 1'b1; blk_valid = 1'b1; blk_last = 1'b0;
      expect_ev(K_CLR, c + 1, -1, -1);
      for (int k = 0; k < 5; k++)
         expect_ev(K_ABS, c + 3 + 4 * k, k + 1, (k + 1 > 3) ? 3 : k + 1);
      expect_ev(K_DV, c + 22, 5, 3);
      step(); start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         wait_until(c + 2 + 4 * k);
         if (k == 4) blk_last = 1'b1;
         wait_until(c + 5 + 4 * k);
         rounds_done = 1'b1; step(); rounds_done = 1'b0;
      end
      blk_valid = 1'b0; blk_last = 1'b0;
      wait_until(c + 23); digest_ack = 1'b1; step(); digest_ack = 1'b0;
      chk("busy_after_sat", int'(busy), 0);
      chk("sb_drained_sat", exp_q.size(), 0);

      step(); step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
